// File: rtl/adc_des_pkg.sv
// Shared types and constants for the codec ADC deserializer.
package adc_des_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned FRAME_BITS = 2 * DATA_W_DEF;
    localparam int unsigned OVF_CNT_W  = 8;

    // Bit counter must hold the value FRAME_BITS itself, not just FRAME_BITS-1
    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus rising-edge detect
// against a one-cycle-delayed copy of the synchronized value.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_c_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchronizer chain and delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_c_o = sync_q & ~dly_q;

endmodule

// File: rtl/adc_deserializer.sv
// Codec ADC serial-to-parallel deserializer with a one-entry output buffer.
// Frames start on an adc_lr_clk rising edge and are shifted MSB first on
// b_clk rising edges. A frame completing while the buffer is still full is
// dropped and flagged in the sticky overflow bit.
// Optional feature: define ADC_OVF_COUNT_EN to add the saturating ovf_count
// output that counts dropped frames.
module adc_deserializer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAME_BITS = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              b_clk,
    input  logic              adc_lr_clk,
    input  logic              adcdat,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    input  logic              overflow_clr
`ifdef ADC_OVF_COUNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    import adc_des_pkg::*;

    localparam int unsigned CW = cnt_width(FRAME_BITS);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0]     left_q, left_d;
    logic [DATA_W-1:0]     right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  dat_meta_q, dat_sync_q;
    logic                  b_rise_c;
    logic                  lr_rise_c;
    logic                  drop_c;
`ifdef ADC_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
`endif

    sync_edge u_bclk_sync (
        .clk      (clk),
        .reset    (reset),
        .d_i      (b_clk),
        .rise_c_o (b_rise_c)
    );

    sync_edge u_lrclk_sync (
        .clk      (clk),
        .reset    (reset),
        .d_i      (adc_lr_clk),
        .rise_c_o (lr_rise_c)
    );

    // Data synchronizer, same depth as the clock synchronizers so a bit is
    // sampled in the cycle its b_clk rising edge is detected
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
        end else begin
            dat_meta_q <= adcdat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Next-state, shift/count datapath and output-buffer control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_c  = 1'b0;

        // Consumer handshake; a LOAD below may refill in the same cycle
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        // Clear first so a same-cycle drop below wins
        if (overflow_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE, SHIFT: begin
                if (lr_rise_c) begin
                    // New frame; any partial frame is discarded silently
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                    if (b_rise_c) begin
                        shreg_d = FRAME_BITS'(dat_sync_q);
                        cnt_d   = CW'(1);
                    end
                end else if ((state_q == SHIFT) && b_rise_c) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], dat_sync_q};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = IDLE;
                if (!valid_q || sample_ready) begin
                    left_d  = shreg_q[FRAME_BITS-1 -: DATA_W];
                    right_d = shreg_q[DATA_W-1:0];
                    valid_d = 1'b1;
                end else begin
                    drop_c = 1'b1;
                    ovf_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ADC_OVF_COUNT_EN
        ovf_cnt_d = ovf_cnt_q;
        if (overflow_clr) begin
            ovf_cnt_d = '0;
        end
        if (drop_c && (ovf_cnt_d != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_d + OVF_CNT_W'(1);
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ADC_OVF_COUNT_EN
    // Dropped-frame counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_adc_deserializer.sv
// Self-checking bench for adc_deserializer: drives codec-style serial frames
// (b_clk = clk/8, data and frame clock change on b_clk falling edge) and
// compares captured sample pairs against frame words split arithmetically.
module tb_adc_deserializer;

    logic        clk;
    logic        reset;
    logic        b_clk;
    logic        adc_lr_clk;
    logic        adcdat;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        overflow;
    logic        overflow_clr;
`ifdef ADC_OVF_COUNT_EN
    logic [7:0]  ovf_count;
`endif

    int          checks;
    int          failures;
    logic [31:0] got_q[$];
    int          rises;
    logic        prev_v;

    adc_deserializer dut (
        .clk          (clk),
        .reset        (reset),
        .b_clk        (b_clk),
        .adc_lr_clk   (adc_lr_clk),
        .adcdat       (adcdat),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef ADC_OVF_COUNT_EN
        ,
        .ovf_count    (ovf_count)
`endif
    );

    // 50 MHz system clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Record accepted pairs and count sample_valid rising edges
    always @(negedge clk) begin
        if (!reset && sample_valid === 1'b1 && sample_ready === 1'b1)
            got_q.push_back({left_data, right_data});
        if (sample_valid === 1'b1 && prev_v !== 1'b1)
            rises++;
        prev_v = sample_valid;
    end

    // Shift nbits of f MSB first; frame clock high for the first half of the
    // bits sent. lat = negedges from last b_clk rise until sample_valid seen.
    task automatic send_frame(input logic [31:0] f, input int nbits,
                              input bit clr_at_load, output int lat);
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            b_clk      = 1'b0;
            adcdat     = f[31-i];
            adc_lr_clk = (2 * i < nbits);
            repeat (4) @(negedge clk);
            b_clk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == nbits - 1) begin
                    if (lat == 0 && sample_valid === 1'b1) lat = k;
                    if (clr_at_load && k == 3) overflow_clr = 1'b1;
                    if (k == 4) overflow_clr = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            b_clk      = 1'b0;
            adcdat     = 1'($urandom);
            adc_lr_clk = 1'b0;
            repeat (4) @(negedge clk);
            b_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sample_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got valid=%b ovf=%b exp 0/0", sample_valid, overflow);
        end
        checks++;
        if (left_data !== 16'h0 || right_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got %h/%h exp 0000/0000", left_data, right_data);
        end
`ifdef ADC_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_ovf_count got %0d exp 0", ovf_count);
        end
`endif
        reset = 1'b0;
        idle_bits(2);
        checks++;
        if (sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_valid got %b exp 0", sample_valid);
        end
    endtask

    task automatic test_single();
        int          lat;
        logic [31:0] f;
        logic [31:0] g;
        f = 32'hA5A5_3C3C;
        got_q.delete();
        rises = 0;
        send_frame(f, 32, 1'b0, lat);
        idle_bits(2);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL single_latency got %0d negedges exp 4", lat);
        end
        checks++;
        if (rises !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("FAIL single_count got rises=%0d pairs=%0d exp 1/1", rises, got_q.size());
        end else begin
            g = got_q[0];
            checks++;
            if (g[31:16] !== 16'(f >> 16) || g[15:0] !== 16'(f % 32'h10000)) begin
                failures++;
                $display("FAIL single_data got %h/%h exp %h/%h", g[31:16], g[15:0],
                         16'(f >> 16), 16'(f % 32'h10000));
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_ovf got %b exp 0", overflow);
        end
    endtask

    task automatic test_overflow();
        int lat;
        sample_ready = 1'b0;
        send_frame(32'h1111_2222, 32, 1'b0, lat);
        send_frame(32'h3333_4444, 32, 1'b0, lat);
        idle_bits(2);
        checks++;
        if (sample_valid !== 1'b1 || left_data !== 16'h1111 || right_data !== 16'h2222) begin
            failures++;
            $display("FAIL ovf_buffer got v=%b %h/%h exp 1 1111/2222", sample_valid, left_data, right_data);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got %b exp 1", overflow);
        end
`ifdef ADC_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd1) begin
            failures++;
            $display("FAIL ovf_count got %0d exp 1", ovf_count);
        end
`endif
        // Clear pulsed in the same cycle as a further drop: set must win
        send_frame(32'h5555_6666, 32, 1'b1, lat);
        idle_bits(1);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got %b exp 1", overflow);
        end
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got %b exp 0", overflow);
        end
`ifdef ADC_OVF_COUNT_EN
        checks++;
        if (ovf_count !== 8'd0) begin
            failures++;
            $display("FAIL ovf_count_clr got %0d exp 0", ovf_count);
        end
`endif
        checks++;
        if (sample_valid !== 1'b1 || left_data !== 16'h1111 || right_data !== 16'h2222) begin
            failures++;
            $display("FAIL ovf_hold got v=%b %h/%h exp 1 1111/2222", sample_valid, left_data, right_data);
        end
    endtask

    task automatic test_abort_lr();
        int          lat;
        logic [31:0] f;
        logic [31:0] g;
        sample_ready = 1'b1;
        f = 32'h8001_7FFE;
        got_q.delete();
        rises = 0;
        send_frame($urandom, 10, 1'b0, lat);
        send_frame(f, 32, 1'b0, lat);
        idle_bits(2);
        checks++;
        if (rises !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("FAIL abort_lr_count got rises=%0d pairs=%0d exp 1/1", rises, got_q.size());
        end else begin
            g = got_q[0];
            checks++;
            if (g[31:16] !== 16'(f >> 16) || g[15:0] !== 16'(f % 32'h10000)) begin
                failures++;
                $display("FAIL abort_lr_data got %h/%h exp 8001/7ffe", g[31:16], g[15:0]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_lr_ovf got %b exp 0", overflow);
        end
    endtask

    task automatic test_abort_reset();
        int          lat;
        logic [31:0] f;
        logic [31:0] g;
        f = 32'h0F0F_F0F0;
        got_q.delete();
        rises = 0;
        send_frame($urandom, 20, 1'b0, lat);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_bits(12);
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL abort_reset_none got rises=%0d exp 0", rises);
        end
        send_frame(f, 32, 1'b0, lat);
        idle_bits(2);
        checks++;
        if (rises !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("FAIL abort_reset_count got rises=%0d pairs=%0d exp 1/1", rises, got_q.size());
        end else begin
            g = got_q[0];
            checks++;
            if (g[31:16] !== 16'(f >> 16) || g[15:0] !== 16'(f % 32'h10000)) begin
                failures++;
                $display("FAIL abort_reset_data got %h/%h exp 0f0f/f0f0", g[31:16], g[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] fr[4];
        logic [31:0] g;
        got_q.delete();
        rises = 0;
        for (int i = 0; i < 4; i++) fr[i] = $urandom;
        for (int i = 0; i < 4; i++) send_frame(fr[i], 32, 1'b0, lat);
        idle_bits(2);
        checks++;
        if (rises !== 4 || got_q.size() !== 4) begin
            failures++;
            $display("FAIL b2b_count got rises=%0d pairs=%0d exp 4/4", rises, got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                g = got_q[i];
                checks++;
                if (g[31:16] !== 16'(fr[i] >> 16) || g[15:0] !== 16'(fr[i] % 32'h10000)) begin
                    failures++;
                    $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", i, g[31:16], g[15:0],
                             16'(fr[i] >> 16), 16'(fr[i] % 32'h10000));
                end
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf got %b exp 0", overflow);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rises        = 0;
        prev_v       = 1'b0;
        reset        = 1'b1;
        b_clk        = 1'b0;
        adc_lr_clk   = 1'b0;
        adcdat       = 1'b0;
        sample_ready = 1'b0;
        overflow_clr = 1'b0;
        @(negedge clk);

        test_reset();
        sample_ready = 1'b1;
        test_single();
        test_overflow();
        test_reset();
        test_abort_lr();
        test_abort_reset();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
